// File: rtl/expansion_pkg.sv
// Shared types and constants for the expansion shift-register frame sequencer.
package expansion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  // Ticks SHIFT_LOAD is held low for the 165 parallel load and the 595 latch.
  localparam int LOAD_TICKS    = 2;
  localparam int LATCH_TICKS   = 2;

  localparam int FRAME_COUNT_W = 16;

endpackage

// File: rtl/shiftreg_tick_gen.sv
// Tick generator: one-cycle pulse every DIVIDER clk cycles, with synchronous restart.
module shiftreg_tick_gen #(
  parameter int DIVIDER = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int                CNT_W = $clog2(DIVIDER + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIVIDER - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-DIVIDER counter; restart forces it back to zero so a
  // frame's first tick lands exactly DIVIDER cycles after the restart.
  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/expansion_shiftreg_ctrl.sv
// Frame sequencer for a daisy-chained 74HC165 / 74HC595 expansion chain:
// parallel-load inputs, shift WIDTH bits full-duplex, latch outputs, publish.
module expansion_shiftreg_ctrl
  import expansion_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIVIDER = 100
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [WIDTH-1:0]         data_out,
  output logic [WIDTH-1:0]         data_in,
  output logic                     busy,
  output logic                     frame_done,
  output logic [FRAME_COUNT_W-1:0] frame_count,
  output logic                     SHIFT_CLK,
  output logic                     SHIFT_LOAD,
  output logic                     SHIFT_OUT,
  input  logic                     SHIFT_IN
);

  localparam int               BIT_W       = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(WIDTH - 1);
  localparam logic [1:0]       LOAD_LAST   = 2'(LOAD_TICKS - 1);
  localparam logic [1:0]       LATCH_LAST  = 2'(LATCH_TICKS - 1);

  state_t           state;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;
  logic [BIT_W-1:0] bit_idx;
  logic [1:0]       ph_cnt;
  logic             tick;

  // Holding the tick counter in restart throughout IDLE means every frame
  // begins with a fresh count on its first PRELOAD cycle.
  shiftreg_tick_gen #(
    .DIVIDER (DIVIDER)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (state == IDLE),
    .tick    (tick)
  );

  // Frame FSM with registered chain pins and result outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      SHIFT_CLK   <= 1'b0;
      SHIFT_LOAD  <= 1'b1;
      SHIFT_OUT   <= 1'b0;
      data_in     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      bit_idx     <= '0;
      ph_cnt      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || continuous) begin
            tx         <= data_out;
            busy       <= 1'b1;
            SHIFT_LOAD <= 1'b0;
            ph_cnt     <= '0;
            state      <= PRELOAD;
          end
        end
        PRELOAD: begin
          if (tick) begin
            if (ph_cnt == LOAD_LAST) begin
              // tx is consumed MSB-first by shifting left; zeros fill in, so
              // SHIFT_OUT naturally returns to 0 after the last bit.
              SHIFT_LOAD <= 1'b1;
              SHIFT_OUT  <= tx[WIDTH-1];
              tx         <= {tx[WIDTH-2:0], 1'b0};
              bit_idx    <= '0;
              state      <= SHIFT;
            end else begin
              ph_cnt <= ph_cnt + 2'd1;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!SHIFT_CLK) begin
              // Sample on the rising cycle, before the 165 advances.
              SHIFT_CLK <= 1'b1;
              rx        <= {rx[WIDTH-2:0], SHIFT_IN};
            end else begin
              SHIFT_CLK <= 1'b0;
              SHIFT_OUT <= tx[WIDTH-1];
              tx        <= {tx[WIDTH-2:0], 1'b0};
              if (bit_idx == BIT_LAST) begin
                SHIFT_LOAD <= 1'b0;
                ph_cnt     <= '0;
                state      <= LATCH;
              end else begin
                bit_idx <= bit_idx + BIT_W'(1);
              end
            end
          end
        end
        LATCH: begin
          if (tick) begin
            if (ph_cnt == LATCH_LAST) begin
              // Publish in the same edge that raises SHIFT_LOAD so data_in,
              // frame_done and frame_count all become visible in DONE.
              SHIFT_LOAD  <= 1'b1;
              data_in     <= rx;
              frame_done  <= 1'b1;
              frame_count <= frame_count + FRAME_COUNT_W'(1);
              state       <= DONE;
            end else begin
              ph_cnt <= ph_cnt + 2'd1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expansion_shiftreg_ctrl.sv
// Directed bench for expansion_shiftreg_ctrl with a 165/595 chain model.
module tb_expansion_shiftreg_ctrl;

  localparam int WIDTH   = 16;
  localparam int DIVIDER = 4;
  localparam int FRAME_BUSY = (2 * WIDTH + 4) * DIVIDER + 1;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             continuous;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_count;
  logic             SHIFT_CLK;
  logic             SHIFT_LOAD;
  logic             SHIFT_OUT;
  logic             SHIFT_IN;

  // chain model state
  logic [WIDTH-1:0] chain_in;
  logic [WIDTH-1:0] sr165;
  logic [WIDTH-1:0] sr595;
  logic [WIDTH-1:0] latched595;

  int n_cmp = 0;
  int n_err = 0;
  int clk_rises = 0;
  int fd_pulses = 0;

  expansion_shiftreg_ctrl #(
    .WIDTH   (WIDTH),
    .DIVIDER (DIVIDER)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .continuous  (continuous),
    .data_out    (data_out),
    .data_in     (data_in),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .SHIFT_CLK   (SHIFT_CLK),
    .SHIFT_LOAD  (SHIFT_LOAD),
    .SHIFT_OUT   (SHIFT_OUT),
    .SHIFT_IN    (SHIFT_IN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 165 chain: load while SHIFT_LOAD falls low, shift toward MSB on SHIFT_CLK rise.
  always @(posedge SHIFT_CLK or negedge SHIFT_LOAD) begin
    if (!SHIFT_LOAD) sr165 <= chain_in;
    else             sr165 <= {sr165[WIDTH-2:0], 1'b0};
  end
  assign SHIFT_IN = sr165[WIDTH-1];

  // 595 chain: shift on SHIFT_CLK rise, latch on SHIFT_LOAD rise.
  always @(posedge SHIFT_CLK) sr595 <= {sr595[WIDTH-2:0], SHIFT_OUT};
  always @(posedge SHIFT_LOAD) latched595 <= sr595;

  // Event monitors.
  always @(posedge SHIFT_CLK) clk_rises++;
  always @(posedge clk) if (frame_done === 1'b1) fd_pulses++;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Pulse start for one cycle; returns at the negedge where busy should be up.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count busy cycles from the current one until busy drops (bounded).
  task automatic wait_not_busy(output int len);
    len = 0;
    while (busy === 1'b1 && len < 2000) begin
      len++;
      step();
    end
  endtask

  task automatic test_reset();
    int r0;
    do_reset();
    r0 = clk_rises;
    repeat (50) step();
    n_cmp++; if (SHIFT_LOAD !== 1'b1) begin n_err++; $display("FAIL reset_load got=%b exp=1", SHIFT_LOAD); end
    n_cmp++; if (SHIFT_CLK !== 1'b0) begin n_err++; $display("FAIL reset_clk got=%b exp=0", SHIFT_CLK); end
    n_cmp++; if (SHIFT_OUT !== 1'b0) begin n_err++; $display("FAIL reset_out got=%b exp=0", SHIFT_OUT); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    n_cmp++; if (data_in !== 16'h0000) begin n_err++; $display("FAIL reset_data_in got=%h exp=0000", data_in); end
    n_cmp++; if (clk_rises - r0 !== 0) begin n_err++; $display("FAIL reset_no_edges got=%0d exp=0", clk_rises - r0); end
  endtask

  task automatic test_single_frame();
    int r0, f0, len;
    do_reset();
    data_out = 16'hA55A;
    chain_in = 16'h1234;
    r0 = clk_rises;
    f0 = fd_pulses;
    pulse_start();
    n_cmp++; if (busy !== 1'b1 || SHIFT_LOAD !== 1'b0) begin n_err++; $display("FAIL single_start_latency busy=%b load=%b exp busy=1 load=0", busy, SHIFT_LOAD); end
    wait_not_busy(len);
    n_cmp++; if (len !== FRAME_BUSY) begin n_err++; $display("FAIL single_busy_len got=%0d exp=%0d", len, FRAME_BUSY); end
    n_cmp++; if (clk_rises - r0 !== WIDTH) begin n_err++; $display("FAIL single_clk_rises got=%0d exp=%0d", clk_rises - r0, WIDTH); end
    n_cmp++; if (latched595 !== 16'hA55A) begin n_err++; $display("FAIL single_latched got=%h exp=a55a", latched595); end
    n_cmp++; if (data_in !== 16'h1234) begin n_err++; $display("FAIL single_data_in got=%h exp=1234", data_in); end
    n_cmp++; if (fd_pulses - f0 !== 1) begin n_err++; $display("FAIL single_done_pulses got=%0d exp=1", fd_pulses - f0); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", frame_count); end
    n_cmp++; if (SHIFT_OUT !== 1'b0 || SHIFT_LOAD !== 1'b1) begin n_err++; $display("FAIL single_idle_pins out=%b load=%b exp out=0 load=1", SHIFT_OUT, SHIFT_LOAD); end
  endtask

  task automatic test_data_out_change();
    int cyc, len;
    do_reset();
    data_out = 16'hA55A;
    chain_in = 16'h5678;
    pulse_start();
    cyc = 1;
    while (busy === 1'b1 && cyc < 2000) begin
      if (cyc == 20) data_out = 16'hFFFF;
      cyc++;
      step();
    end
    n_cmp++; if (cyc - 1 !== FRAME_BUSY) begin n_err++; $display("FAIL chg_busy_len got=%0d exp=%0d", cyc - 1, FRAME_BUSY); end
    n_cmp++; if (latched595 !== 16'hA55A) begin n_err++; $display("FAIL chg_latched_first got=%h exp=a55a", latched595); end
    n_cmp++; if (data_in !== 16'h5678) begin n_err++; $display("FAIL chg_data_in got=%h exp=5678", data_in); end
    step();
    pulse_start();
    wait_not_busy(len);
    n_cmp++; if (latched595 !== 16'hFFFF) begin n_err++; $display("FAIL chg_latched_second got=%h exp=ffff", latched595); end
    n_cmp++; if (frame_count !== 16'd2) begin n_err++; $display("FAIL chg_count got=%0d exp=2", frame_count); end
  endtask

  task automatic test_continuous();
    logic [WIDTH-1:0] vals [3];
    int n, gap;
    vals[0] = 16'h0001;
    vals[1] = 16'h8000;
    vals[2] = 16'hFFFF;
    do_reset();
    data_out = 16'h0000;
    chain_in = vals[0];
    continuous = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (frame_done !== 1'b1 && n < 400) begin
        n++;
        step();
      end
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL cont_frame_timeout frame=%0d done=%b exp=1", f, frame_done); end
      n_cmp++; if (data_in !== vals[f]) begin n_err++; $display("FAIL cont_data_in frame=%0d got=%h exp=%h", f, data_in, vals[f]); end
      if (f < 2) chain_in = vals[f + 1];
      step();
      gap = 0;
      while (busy !== 1'b1 && gap < 20) begin
        gap++;
        step();
      end
      if (f < 2) begin
        n_cmp++; if (gap !== 1) begin n_err++; $display("FAIL cont_gap frame=%0d got=%0d exp=1", f, gap); end
      end else begin
        n_cmp++; if (gap !== 20) begin n_err++; $display("FAIL cont_stop idle_cycles=%0d exp=20", gap); end
      end
      if (f == 1) continuous = 1'b0;
    end
    n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL cont_count got=%0d exp=3", frame_count); end
  endtask

  task automatic test_start_ignored();
    int f0, cyc;
    do_reset();
    data_out = 16'h0F0F;
    chain_in = 16'h3C3C;
    f0 = fd_pulses;
    pulse_start();
    cyc = 1;
    while (busy === 1'b1 && cyc < 2000) begin
      start = (cyc == 10);
      cyc++;
      step();
    end
    start = 1'b0;
    repeat (20) step();
    n_cmp++; if (fd_pulses - f0 !== 1) begin n_err++; $display("FAIL ign_done_pulses got=%0d exp=1", fd_pulses - f0); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL ign_count got=%0d exp=1", frame_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy got=%b exp=0", busy); end
    n_cmp++; if (data_in !== 16'h3C3C) begin n_err++; $display("FAIL ign_data_in got=%h exp=3c3c", data_in); end
    n_cmp++; if (latched595 !== 16'h0F0F) begin n_err++; $display("FAIL ign_latched got=%h exp=0f0f", latched595); end
  endtask

  task automatic test_reset_mid_frame();
    int len;
    do_reset();
    data_out = 16'h1111;
    chain_in = 16'hBEEF;
    pulse_start();
    repeat (59) step();
    reset_n = 1'b0;
    step();
    n_cmp++; if (SHIFT_CLK !== 1'b0 || SHIFT_LOAD !== 1'b1 || SHIFT_OUT !== 1'b0) begin n_err++; $display("FAIL rst_mid_pins clk=%b load=%b out=%b exp 0/1/0", SHIFT_CLK, SHIFT_LOAD, SHIFT_OUT); end
    n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags busy=%b done=%b exp 0/0", busy, frame_done); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rst_mid_count got=%0d exp=0", frame_count); end
    reset_n = 1'b1;
    repeat (10) step();
    n_cmp++; if (data_in !== 16'h0000) begin n_err++; $display("FAIL rst_mid_data_in got=%h exp=0000", data_in); end
    pulse_start();
    wait_not_busy(len);
    n_cmp++; if (len !== FRAME_BUSY) begin n_err++; $display("FAIL rst_fresh_busy_len got=%0d exp=%0d", len, FRAME_BUSY); end
    n_cmp++; if (data_in !== 16'hBEEF) begin n_err++; $display("FAIL rst_fresh_data_in got=%h exp=beef", data_in); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL rst_fresh_count got=%0d exp=1", frame_count); end
    n_cmp++; if (latched595 !== 16'h1111) begin n_err++; $display("FAIL rst_fresh_latched got=%h exp=1111", latched595); end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    data_out   = '0;
    chain_in   = '0;
    step();
    test_reset();
    test_single_frame();
    test_data_out_change();
    test_continuous();
    test_start_ignored();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/expansion_shiftreg_ctrl.md
# expansion_shiftreg_ctrl

Frame sequencer for a daisy-chained 74HC165 (input) / 74HC595 (output) expansion chain on one shared SHIFT_CLK / SHIFT_LOAD / SHIFT_OUT / SHIFT_IN bundle. It replaces free-running bit shifting with explicit frames: parallel-load inputs, shift WIDTH bits full-duplex, latch outputs, then publish results atomically. It sits between the expansion pins and the RIO register interface, and exposes a start/busy/done handshake plus a continuous-refresh mode.

## Interface
- WIDTH, 16: chain length in bits; multiple of 8; 8..256.
- DIVIDER, 100: clk cycles per SHIFT_CLK half-period (one "tick"); ≥1.
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  reset: synchronous, active-low.
- start  in  1  request one frame; sampled only in IDLE.
- continuous  in  1  when 1, IDLE auto-starts a frame as if start=1.
- data_out  in  WIDTH  bits for the 595 chain; MSB is shifted first.
- data_in  out  WIDTH  last complete 165 frame; MSB is the first bit received.
- busy  out  1  high from the frame's first cycle through DONE.
- frame_done  out  1  one-cycle pulse when data_in updates.
- frame_count  out  16  completed frames; wraps 0xFFFF→0.
- SHIFT_CLK  out  1  chain shift clock.
- SHIFT_LOAD  out  1  active-low 165 load; its rising edge is the 595 latch.
- SHIFT_OUT  out  1  serial data to the 595 chain.
- SHIFT_IN  in  1  serial data from the 165 chain; synchronous to clk by construction.

## Operation
- Reset values: SHIFT_CLK=0, SHIFT_LOAD=1, SHIFT_OUT=0, data_in=0, busy=0, frame_done=0, frame_count=0, state=IDLE, tick counter=0.
- IDLE: on start|continuous, capture data_out into shadow register `tx`, clear the tick counter, set busy=1, SHIFT_LOAD=0, and go to PRELOAD.
- PRELOAD: hold SHIFT_LOAD=0 and SHIFT_CLK=0 for 2 ticks (165 parallel load), then set SHIFT_LOAD=1, SHIFT_OUT=tx[WIDTH-1], bit=0, and go to SHIFT.
- SHIFT: for each bit, SHIFT_CLK stays low for 1 tick, then rises.
  - On the rising cycle, shift SHIFT_IN into `rx` LSB-first, so the first received bit ends up in the MSB.
  - SHIFT_CLK then stays high for 1 tick and falls.
  - On the falling cycle, SHIFT_OUT takes the next tx bit, or 0 after the last bit.
  - After WIDTH bits, go to LATCH.
- LATCH: SHIFT_LOAD=0 for 2 ticks, then SHIFT_LOAD=1. That rising edge latches the 595 outputs. Go to DONE.
- DONE: one cycle. data_in←rx, frame_done=1, frame_count+1, busy=0 on the next cycle, return to IDLE.
- start while busy is ignored, not queued. data_out changes mid-frame do not affect the current frame.
- continuous deasserted mid-frame: the current frame completes; no new frame starts.
- Reset mid-frame: next edge restores all reset values; data_in is not updated with a partial frame.

## Timing
- Tick = DIVIDER clk cycles, counted with a clog2(DIVIDER+1)-bit counter. The counter is restarted by each frame start.
- start high in cycle t (IDLE) → busy=1 and SHIFT_LOAD=0 at t+1.
- Phase lengths: PRELOAD 2·DIVIDER cycles, SHIFT 2·WIDTH·DIVIDER, LATCH 2·DIVIDER, DONE 1.
- busy is high for exactly (2·WIDTH+4)·DIVIDER+1 cycles. frame_done is asserted in the last of them.
- Continuous mode: exactly one IDLE cycle (busy=0) between frames, so the frame period is (2·WIDTH+4)·DIVIDER+2.
- SHIFT_OUT changes only on SHIFT_CLK falling cycles and at SHIFT entry, giving ≥1 tick of setup and hold around each rising edge.
- frame_count increments in the same cycle as the frame_done pulse.

## Structure
- Shared package `expansion_pkg`:
  - state enum IDLE/PRELOAD/SHIFT/LATCH/DONE
  - LOAD_TICKS=2 and LATCH_TICKS=2 constants
  - FRAME_COUNT_W=16
- One sub-module, `shiftreg_tick_gen`: DIVIDER-cycle tick pulse with synchronous restart.
- All remaining logic is in `expansion_shiftreg_ctrl`.

## Test plan
Bench parameters: WIDTH=16, DIVIDER=4. The bench includes a 165/595 chain model.
- Reset, then idle 50 cycles → SHIFT_LOAD=1, SHIFT_CLK=0, busy=0, frame_count=0, and no SHIFT_CLK edges.
- data_out=0xA55A, chain inputs 0x1234, one start pulse → busy high 145 cycles, 16 SHIFT_CLK rises, model 595 latches 0xA55A, data_in=0x1234, frame_done pulse once, frame_count=1.
- data_out changed to 0xFFFF at cycle 20 of a frame → model latches the original 0xA55A; the next frame latches 0xFFFF.
- continuous=1 for 3 frames with inputs 0x0001, 0x8000, 0xFFFF → data_in follows in order, busy gaps are exactly 1 cycle, frame_count=3.
- start re-pulsed at cycle 10 of a busy frame → ignored; exactly one frame_done.
- reset_n low at cycle 60 of a frame, inputs 0xBEEF → all outputs at reset values next cycle; data_in stays 0; a fresh start completes normally with data_in=0xBEEF.
